// File: rtl/axi_lite_rd_arbiter.sv
// rtl/axi_lite_rd_arbiter.sv - two-master round-robin AXI4-Lite read-channel arbiter
module axi_lite_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state, state_d;
  logic              grant, grant_d;
  logic              last_grant, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              win0, win1;

  // On a tie the master that was not served last wins.
  assign win0 = m0_arvalid & (~m1_arvalid | last_grant);
  assign win1 = m1_arvalid & ~win0;

  assign s_araddr = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    addr_d       = addr_q;
    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    m0_rvalid    = 1'b0;
    m0_rdata     = '0;
    m0_rresp     = 2'b00;
    m1_rvalid    = 1'b0;
    m1_rdata     = '0;
    m1_rresp     = 2'b00;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    // Outputs are forced quiet for the whole time reset is held, not just after the edge.
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          m0_arready = win0;
          m1_arready = win1;
          if (win0 | win1) begin
            grant_d      = win1;
            last_grant_d = win1;
            addr_d       = win1 ? m1_araddr : m0_araddr;
            state_d      = ADDR;
          end
        end
        ADDR: begin
          s_arvalid = 1'b1;
          if (s_arready) state_d = DATA;
        end
        DATA: begin
          if (grant) begin
            m1_rvalid = s_rvalid;
            m1_rdata  = s_rdata;
            m1_rresp  = s_rresp;
            s_rready  = m1_rready;
          end else begin
            m0_rvalid = s_rvalid;
            m0_rdata  = s_rdata;
            m0_rresp  = s_rresp;
            s_rready  = m0_rready;
          end
          if (s_rvalid && s_rready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// tb/tb_axi_lite_rd_arbiter.sv - self-checking bench for the two-master read arbiter
module tb_axi_lite_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_arvalid = 1'b0, m1_arvalid = 1'b0;
  logic          m0_arready, m1_arready;
  logic [AW-1:0] m0_araddr = '0, m1_araddr = '0;
  logic          m0_rvalid, m1_rvalid;
  logic          m0_rready = 1'b0, m1_rready = 1'b0;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [1:0]    m0_rresp, m1_rresp;
  logic          s_arvalid, s_arready;
  logic [AW-1:0] s_araddr;
  logic          s_rvalid = 1'b0;
  logic          s_rready;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]    s_rresp = 2'b00;

  int checks = 0;
  int errors = 0;

  axi_lite_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SRAM contents and responses as a pure function of the address
  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {a[15:0], 16'h0413};
  endfunction
  function automatic logic [1:0] sram_resp(input logic [31:0] a);
    return a[5:4];
  endfunction

  // Slave model: 1-cycle SRAM with programmable AR stall
  int            ar_stall = 0;
  int            ar_wait = 0;
  logic          sbusy = 1'b0;
  logic [AW-1:0] raddr = '0;
  assign s_arready = !sbusy && (ar_wait >= ar_stall);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbusy    <= 1'b0;
      ar_wait  <= 0;
      s_rvalid <= 1'b0;
    end else if (!sbusy) begin
      if (s_arvalid && s_arready) begin
        sbusy   <= 1'b1;
        raddr   <= s_araddr;
        ar_wait <= 0;
      end else if (s_arvalid) begin
        ar_wait <= ar_wait + 1;
      end
    end else if (!s_rvalid) begin
      s_rvalid <= 1'b1;
      s_rdata  <= sram_word(raddr);
      s_rresp  <= sram_resp(raddr);
    end else if (s_rready) begin
      s_rvalid <= 1'b0;
      sbusy    <= 1'b0;
    end
  end

  // Master drivers present the head of their request queue
  logic [AW-1:0] req0[$], req1[$];
  bit force_low0 = 0, force_low1 = 0, rr_rand = 0, ar_rand = 0;

  always @(posedge clk) begin
    #1;
    m0_arvalid = (req0.size() != 0) && (!ar_rand || ($urandom_range(0, 3) != 0));
    m0_araddr  = (req0.size() != 0) ? req0[0] : '0;
    m0_rready  = !force_low0 && (!rr_rand || ($urandom_range(0, 1) != 0));
    m1_arvalid = (req1.size() != 0) && (!ar_rand || ($urandom_range(0, 3) != 0));
    m1_araddr  = (req1.size() != 0) ? req1[0] : '0;
    m1_rready  = !force_low1 && (!rr_rand || ($urandom_range(0, 1) != 0));
  end

  // Reference model: transaction-level round robin plus per-master expected-address scoreboards
  logic [AW-1:0] exp0[$], exp1[$];
  int  grant_log[$];
  bit  prev_win = 1'b1;
  int  outstanding = 0;
  int  iss0 = 0, iss1 = 0, done0 = 0, done1 = 0;
  bit  hs0, hs1, want;
  logic [AW-1:0] ea;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_win    = 1'b1;
      outstanding = 0;
      exp0.delete();
      exp1.delete();
    end else begin
      hs0 = m0_arvalid && m0_arready;
      hs1 = m1_arvalid && m1_arready;
      if (hs0 || hs1) begin
        want = (m0_arvalid && m1_arvalid) ? !prev_win : m1_arvalid;
        chk("ar_one_winner", 64'(hs0 && hs1), 64'd0);
        chk("ar_winner", 64'(hs1), 64'(want));
        chk("ar_outstanding", 64'(outstanding), 64'd0);
        prev_win = want;
        outstanding = 1;
        grant_log.push_back(hs1 ? 1 : 0);
        if (hs1) begin
          exp1.push_back(m1_araddr);
          void'(req1.pop_front());
        end else begin
          exp0.push_back(m0_araddr);
          void'(req0.pop_front());
        end
      end
      chk("r_exclusive", 64'(m0_rvalid && m1_rvalid), 64'd0);
      if (m0_rvalid && m0_rready) begin
        chk("r0_outstanding", 64'(outstanding), 64'd1);
        if (exp0.size() != 0) begin
          ea = exp0.pop_front();
          chk("r0_rdata", 64'(m0_rdata), 64'(sram_word(ea)));
          chk("r0_rresp", 64'(m0_rresp), 64'(sram_resp(ea)));
        end else chk("r0_unexpected", 64'd1, 64'd0);
        done0++;
        outstanding = 0;
      end
      if (m1_rvalid && m1_rready) begin
        chk("r1_outstanding", 64'(outstanding), 64'd1);
        if (exp1.size() != 0) begin
          ea = exp1.pop_front();
          chk("r1_rdata", 64'(m1_rdata), 64'(sram_word(ea)));
          chk("r1_rresp", 64'(m1_rresp), 64'(sram_resp(ea)));
        end else chk("r1_unexpected", 64'd1, 64'd0);
        done1++;
        outstanding = 0;
      end
    end
  end

  function automatic logic [9:0] out_vec();
    return {m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready,
            |m0_rdata, |m1_rdata, |m0_rresp, |m1_rresp};
  endfunction

  function automatic int log_at(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  task automatic push0(input logic [AW-1:0] a);
    req0.push_back(a);
    iss0++;
  endtask
  task automatic push1(input logic [AW-1:0] a);
    req1.push_back(a);
    iss1++;
  endtask

  task automatic drain(input string tag);
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (req0.size() == 0) && (req1.size() == 0) && (outstanding == 0);
    end
    chk({tag, "_drain"}, 64'(ok), 64'd1);
    chk({tag, "_m0_done"}, 64'(done0), 64'(iss0));
    chk({tag, "_m1_done"}, 64'(done1), 64'(iss1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n0, n1;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(out_vec()), 64'd0);
    chk("reset_s_araddr", 64'(s_araddr), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // T2: first tie after reset goes to M0, then M1
    grant_log.delete();
    push0(32'h8000_0000);
    push1(32'h8000_1000);
    drain("t2a");
    chk("t2a_count", 64'(grant_log.size()), 64'd2);
    chk("t2a_first", 64'(log_at(0)), 64'd0);
    chk("t2a_second", 64'(log_at(1)), 64'd1);
    grant_log.delete();
    push0(32'h8000_0000);
    push1(32'h8000_1000);
    drain("t2b");
    chk("t2b_first", 64'(log_at(0)), 64'd0);
    chk("t2b_second", 64'(log_at(1)), 64'd1);
    grant_log.delete();
    push0(32'h8000_0010);
    push0(32'h8000_0020);
    push1(32'h8000_1030);
    drain("t2c");
    chk("t2c_0", 64'(log_at(0)), 64'd0);
    chk("t2c_1", 64'(log_at(1)), 64'd1);
    chk("t2c_2", 64'(log_at(2)), 64'd0);

    // T1: single M0 read timing
    push0(32'h8000_0000);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = m0_arvalid && m0_arready;
    end
    chk("t1_ar_handshake", 64'(ok), 64'd1);
    @(negedge clk);
    chk("t1_s_arvalid", 64'(s_arvalid), 64'd1);
    chk("t1_s_araddr", 64'(s_araddr), 64'h8000_0000);
    chk("t1_m0_arready_addr", 64'(m0_arready), 64'd0);
    @(negedge clk);
    chk("t1_rvalid_early", 64'(m0_rvalid), 64'd0);
    @(negedge clk);
    chk("t1_rvalid", 64'(m0_rvalid), 64'd1);
    chk("t1_rdata", 64'(m0_rdata), 64'h0000_0413);
    chk("t1_m1_rvalid", 64'(m1_rvalid), 64'd0);
    drain("t1");

    // T3: M1 granted, holds rready low for 3 cycles while M0 waits
    force_low1 = 1;
    push1(32'h8000_1040);
    push0(32'h8000_0050);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = m1_rvalid;
    end
    chk("t3_m1_rvalid_seen", 64'(ok), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      chk("t3_s_rready_low", 64'(s_rready), 64'd0);
      chk("t3_m1_rvalid_hold", 64'(m1_rvalid), 64'd1);
      chk("t3_m0_arready_blocked", 64'(m0_arready), 64'd0);
    end
    force_low1 = 0;
    @(negedge clk);
    chk("t3_s_rready_high", 64'(s_rready), 64'd1);
    @(negedge clk);
    chk("t3_m0_granted_next", 64'(m0_arready), 64'd1);
    drain("t3");

    // T4: slave stalls AR for 2 cycles
    ar_stall = 2;
    push0(32'h8000_0060);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = m0_arvalid && m0_arready;
    end
    chk("t4_ar_handshake", 64'(ok), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_s_arvalid_hold", 64'(s_arvalid), 64'd1);
      chk("t4_s_araddr_hold", 64'(s_araddr), 64'h8000_0060);
    end
    @(negedge clk);
    chk("t4_s_arvalid_done", 64'(s_arvalid), 64'd0);
    drain("t4");
    ar_stall = 0;

    // T6: both masters stream; grants must alternate
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      push0(32'h8000_0100 + 32'(i * 4));
      push1(32'h8000_2000 + 32'(i * 16));
    end
    drain("t6");
    chk("t6_count", 64'(grant_log.size()), 64'd8);
    for (int i = 1; i < 8; i++) chk("t6_alternate", 64'(log_at(i) != log_at(i - 1)), 64'd1);

    // Randomized traffic: dropping arvalid, random rready and AR stalls
    rr_rand = 1;
    ar_rand = 1;
    for (int b = 0; b < 6; b++) begin
      ar_stall = int'($urandom_range(0, 2));
      n0 = int'($urandom_range(0, 6));
      n1 = int'($urandom_range(0, 6));
      for (int i = 0; i < n0; i++) push0($urandom);
      for (int i = 0; i < n1; i++) push1($urandom);
      drain("rand");
    end
    rr_rand = 0;
    ar_rand = 0;
    ar_stall = 0;

    // T5: asynchronous reset while a transaction sits in DATA
    force_low0 = 1;
    force_low1 = 1;
    push0(32'h8000_0070);
    push1(32'h8000_1070);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = m0_rvalid || m1_rvalid;
    end
    chk("t5_in_data", 64'(ok), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_outputs", 64'(out_vec()), 64'd0);
    chk("t5_async_s_araddr", 64'(s_araddr), 64'd0);
    req0.delete();
    req1.delete();
    iss0 = 0;
    iss1 = 0;
    done0 = 0;
    done1 = 0;
    force_low0 = 0;
    force_low1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    grant_log.delete();
    push0(32'h8000_0000);
    push1(32'h8000_1000);
    drain("t5");
    chk("t5_first_tie_m0", 64'(log_at(0)), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
